// File: rtl/sine_lut_phase_scheduler.sv
// -----------------------------------------------------------------------------
// sine_lut_phase_scheduler
//
// Shares one single-port sine half-wave LUT ROM between three phase channels
// (A, B, C) to build a three-phase modulating set for the PWM comparators.
// A clock divider produces the sample tick. On each tick the common phase
// index p is turned into three positions: A = p, B = p + OFFSET_B and
// C = p + OFFSET_C, with B and C wrapped into one period. Each position is
// folded onto the half-wave table, and the fold also decides the sign. The
// three table reads are issued back to back. The signed results are published
// together with a single-cycle out_valid strobe.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   en        run enable (gates the sample tick only; an in-flight read
//             sequence always completes)
//   rom_rd    LUT read strobe
//   rom_addr  LUT address (holds its last value while rom_rd = 0)
//   rom_data  LUT magnitude, valid the cycle after rom_rd
//   out_a/b/c signed two's-complement samples
//   out_valid one-cycle strobe; all three outputs update together
//   busy      high while a read sequence is in flight
// -----------------------------------------------------------------------------
module sine_lut_phase_scheduler #(
  parameter int CLK_DIV    = 12,
  parameter int HALF_DEPTH = 10000,
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 12,
  parameter int OFFSET_B   = 6667,
  parameter int OFFSET_C   = 13333
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_c,
  output logic              out_valid,
  output logic              busy
);

  localparam int PERIOD = 2 * HALF_DEPTH;
  localparam int POS_W  = $clog2(PERIOD);
  localparam int DIV_W  = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_RD_C,
    S_CAP_C
  } state_e;

  // Table address and sign of one channel after half-wave folding.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              neg;
  } fold_t;

  // Position of a channel offset from p, wrapped into [0, PERIOD).
  // The sum is one bit wider so p + offset cannot overflow before the wrap.
  function automatic logic [POS_W-1:0] offset_pos(input logic [POS_W-1:0] p,
                                                  input int offset);
    logic [POS_W:0] sum;
    sum = {1'b0, p} + (POS_W+1)'(offset);
    if (sum >= (POS_W+1)'(PERIOD)) sum = sum - (POS_W+1)'(PERIOD);
    return sum[POS_W-1:0];
  endfunction

  // The second half period mirrors the first with the sign inverted.
  function automatic fold_t fold(input logic [POS_W-1:0] pos);
    fold_t f;
    if (pos < POS_W'(HALF_DEPTH)) begin
      f.addr = ADDR_W'(pos);
      f.neg  = 1'b0;
    end else begin
      f.addr = ADDR_W'(pos - POS_W'(HALF_DEPTH));
      f.neg  = 1'b1;
    end
    return f;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                   input logic neg);
    // The magnitude never exceeds 2^(DATA_W-1)-1, so the negation always fits.
    // Negating zero gives zero.
    return neg ? -mag : mag;
  endfunction

  // State registers and their next-state values
  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [POS_W-1:0]    p_q, p_d;
  logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
  logic [ADDR_W-1:0]   addr_c_q, addr_c_d;
  logic                neg_a_q, neg_a_d;
  logic                neg_b_q, neg_b_d;
  logic                neg_c_q, neg_c_d;
  logic [DATA_W-1:0]   data_a_q, data_a_d;
  logic [DATA_W-1:0]   data_b_q, data_b_d;
  logic                rom_rd_q, rom_rd_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0]   out_a_q, out_a_d;
  logic [DATA_W-1:0]   out_b_q, out_b_d;
  logic [DATA_W-1:0]   out_c_q, out_c_d;
  logic                out_valid_q, out_valid_d;

  logic                tick;
  fold_t               fold_a, fold_b, fold_c;

  always_comb begin
    // NOTE: every signal driven here gets a value before any branch, so an
    // unhandled path holds the register through its _q copy instead of
    // inferring a latch.
    state_d     = state_q;
    p_d         = p_q;
    addr_b_d    = addr_b_q;
    addr_c_d    = addr_c_q;
    neg_a_d     = neg_a_q;
    neg_b_d     = neg_b_q;
    neg_c_d     = neg_c_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    rom_rd_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_c_d     = out_c_q;
    out_valid_d = 1'b0;

    fold_a = fold(p_q);
    fold_b = fold(offset_pos(p_q, OFFSET_B));
    fold_c = fold(offset_pos(p_q, OFFSET_C));

    // The divider is held at 0 while disabled, so re-enabling always gives a
    // full CLK_DIV interval before the next tick.
    tick = en && (div_q == DIV_W'(CLK_DIV - 1));
    if (!en || tick) div_d = '0;
    else             div_d = div_q + 1'b1;

    // rom_rd/rom_addr are registered, so each state sets them for the state
    // it is about to enter. Ticks outside IDLE are ignored.
    unique case (state_q)
      S_IDLE: begin
        if (tick) begin
          neg_a_d    = fold_a.neg;
          addr_b_d   = fold_b.addr;
          neg_b_d    = fold_b.neg;
          addr_c_d   = fold_c.addr;
          neg_c_d    = fold_c.neg;
          p_d        = (p_q == POS_W'(PERIOD - 1)) ? '0 : p_q + 1'b1;
          rom_rd_d   = 1'b1;
          rom_addr_d = fold_a.addr;
          state_d    = S_RD_A;
        end
      end
      S_RD_A: begin
        rom_rd_d   = 1'b1;
        rom_addr_d = addr_b_q;
        state_d    = S_RD_B;
      end
      S_RD_B: begin
        data_a_d   = rom_data;
        rom_rd_d   = 1'b1;
        rom_addr_d = addr_c_q;
        state_d    = S_RD_C;
      end
      S_RD_C: begin
        data_b_d = rom_data;
        state_d  = S_CAP_C;
      end
      S_CAP_C: begin
        out_a_d     = apply_sign(data_a_q, neg_a_q);
        out_b_d     = apply_sign(data_b_q, neg_b_q);
        out_c_d     = apply_sign(rom_data, neg_c_q);
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset is asynchronous, so a mid-sequence reset aborts the sequence at
  // once. No out_valid follows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      p_q         <= '0;
      addr_b_q    <= '0;
      addr_c_q    <= '0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      neg_c_q     <= 1'b0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      rom_rd_q    <= 1'b0;
      rom_addr_q  <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_c_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample its _d
      // value from before the edge, whatever order these lines are in.
      state_q     <= state_d;
      div_q       <= div_d;
      p_q         <= p_d;
      addr_b_q    <= addr_b_d;
      addr_c_q    <= addr_c_d;
      neg_a_q     <= neg_a_d;
      neg_b_q     <= neg_b_d;
      neg_c_q     <= neg_c_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      rom_rd_q    <= rom_rd_d;
      rom_addr_q  <= rom_addr_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_c_q     <= out_c_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rom_rd    = rom_rd_q;
  assign rom_addr  = rom_addr_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_c     = out_c_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sine_lut_phase_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for sine_lut_phase_scheduler.
//
// Two instances are used:
//   dut   -> default parameters
//   dut_s -> a small table (HALF_DEPTH=8, CLK_DIV=6) for the fold and wrap
//            corners
// Each instance has a ROM model that returns rom_addr[10:0] one cycle after
// rom_rd. Expected samples come from a model of the phase, fold and sign
// rules. They are queued when a run is started and popped by a monitor on
// every out_valid. Timing and address checks are directed steps.
// -----------------------------------------------------------------------------
module tb_sine_lut_phase_scheduler;

  localparam int HALF   = 10000;
  localparam int OFF_B  = 6667;
  localparam int OFF_C  = 13333;
  localparam int S_HALF = 8;
  localparam int S_OFFB = 5;
  localparam int S_OFFC = 11;

  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] c;
  } exp_t;

  logic        clk;
  logic        rst_n, en;
  logic        rom_rd, out_valid, busy;
  logic [13:0] rom_addr;
  logic [11:0] rom_data, out_a, out_b, out_c;

  logic        rst_s, en_s;
  logic        rom_rd_s, out_valid_s, busy_s;
  logic [13:0] rom_addr_s;
  logic [11:0] rom_data_s, out_a_s, out_b_s, out_c_s;

  int   checks   = 0;
  int   failures = 0;
  exp_t q_big[$];
  exp_t q_small[$];

  sine_lut_phase_scheduler dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .out_valid(out_valid), .busy(busy)
  );

  sine_lut_phase_scheduler #(
    .CLK_DIV(6), .HALF_DEPTH(S_HALF), .ADDR_W(14), .DATA_W(12),
    .OFFSET_B(S_OFFB), .OFFSET_C(S_OFFC)
  ) dut_s (
    .clk(clk), .rst_n(rst_s), .en(en_s),
    .rom_rd(rom_rd_s), .rom_addr(rom_addr_s), .rom_data(rom_data_s),
    .out_a(out_a_s), .out_b(out_b_s), .out_c(out_c_s),
    .out_valid(out_valid_s), .busy(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM models: 1-cycle read latency, data = address[10:0]
  always @(posedge clk) if (rom_rd)   rom_data   <= {1'b0, rom_addr[10:0]};
  always @(posedge clk) if (rom_rd_s) rom_data_s <= {1'b0, rom_addr_s[10:0]};

  // ---------------- reference model ----------------
  function automatic int wrap_pos(int p, int off, int half);
    int s;
    s = p + off;
    if (s >= 2 * half) s = s - 2 * half;
    return s;
  endfunction

  function automatic int fold_addr(int pos, int half);
    return (pos < half) ? pos : pos - half;
  endfunction

  function automatic logic [11:0] sample_val(int pos, int half);
    logic [11:0] mag;
    mag = 12'(fold_addr(pos, half) % 2048);
    return (pos < half) ? mag : 12'd0 - mag;
  endfunction

  function automatic exp_t model(int p, int half, int offb, int offc);
    exp_t e;
    e.a = sample_val(p, half);
    e.b = sample_val(wrap_pos(p, offb, half), half);
    e.c = sample_val(wrap_pos(p, offc, half), half);
    return e;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: every strobe must have a queued expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      check("big_valid_expected", 32'(q_big.size() != 0), 32'd1);
      if (q_big.size() != 0) begin
        exp_t e;
        e = q_big.pop_front();
        check("big_out_a", out_a, e.a);
        check("big_out_b", out_b, e.b);
        check("big_out_c", out_c, e.c);
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid_s === 1'b1) begin
      check("small_valid_expected", 32'(q_small.size() != 0), 32'd1);
      if (q_small.size() != 0) begin
        exp_t e;
        e = q_small.pop_front();
        check("small_out_a", out_a_s, e.a);
        check("small_out_b", out_b_s, e.b);
        check("small_out_c", out_c_s, e.c);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called right after a negedge where en/rst_n changed; counts posedges
  // until rom_rd is seen.
  task automatic wait_first_read(input string tag, input int exp_cycles);
    int  n;
    bit  seen;
    n    = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (rom_rd === 1'b1) seen = 1;
    end
    check({tag, "_tick_latency"}, n, exp_cycles);
  endtask

  // Starting at the negedge of RD_A, checks the read sequence of sample p
  // and ends on the out_valid negedge.
  task automatic check_read_seq(input string tag, input int p);
    check({tag, "_addr_a"}, rom_addr, fold_addr(p, HALF));
    check({tag, "_busy_rd_a"}, busy, 1);
    @(negedge clk);
    check({tag, "_rd_b"}, rom_rd, 1);
    check({tag, "_addr_b"}, rom_addr, fold_addr(wrap_pos(p, OFF_B, HALF), HALF));
    @(negedge clk);
    check({tag, "_rd_c"}, rom_rd, 1);
    check({tag, "_addr_c"}, rom_addr, fold_addr(wrap_pos(p, OFF_C, HALF), HALF));
    @(negedge clk);
    check({tag, "_rd_cap"}, rom_rd, 0);
    check({tag, "_addr_hold"}, rom_addr, fold_addr(wrap_pos(p, OFF_C, HALF), HALF));
    check({tag, "_busy_cap"}, busy, 1);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_busy_done"}, busy, 0);
  endtask

  // Waits for the next out_valid on dut, counting cycles and busy cycles.
  task automatic wait_valid(output int gap, output int bcnt);
    gap  = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      gap++;
      if (busy === 1'b1) bcnt++;
      if (gap == 1) check("valid_one_cycle", out_valid, 0);
    end while (out_valid !== 1'b1 && gap < 40);
  endtask

  task automatic wait_read_start(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rom_rd !== 1'b1 && n < 40);
    check({tag, "_read_start"}, rom_rd, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int gap, bcnt, rd_cnt, v_cnt, n;

    rst_n = 1'b0; en = 1'b1;
    rst_s = 1'b0; en_s = 1'b1;
    repeat (3) @(negedge clk);

    // Scenario 1: reset state, then the first sample
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_out_c", out_c, 0);
    check("rst_rom_rd", rom_rd, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_small_rom_rd", rom_rd_s, 0);

    q_big.push_back(model(0, HALF, OFF_B, OFF_C));
    rst_n = 1'b1;
    wait_first_read("s1", 12);
    check_read_seq("s1", 0);
    check("s1_out_a_const", out_a, 12'd0);
    check("s1_out_b_const", out_b, 12'd523);
    check("s1_out_c_const", out_c, 12'hAFB);

    // Scenario 2: free run, 50 samples with p = 1..50
    for (int k = 1; k <= 50; k++) q_big.push_back(model(k, HALF, OFF_B, OFF_C));
    for (int k = 1; k <= 50; k++) begin
      wait_valid(gap, bcnt);
      check("s2_valid_period", gap, 12);
      check("s2_busy_cycles", bcnt, 4);
    end

    // Scenario 4: drop en during RD_B of the p=51 sample
    q_big.push_back(model(51, HALF, OFF_B, OFF_C));
    wait_read_start("s4");
    @(posedge clk);
    #1 en = 1'b0;
    wait_valid(gap, bcnt);
    check("s4_drain_gap", gap, 4);
    check("s4_drain_valid", out_valid, 1);
    rd_cnt = 0;
    v_cnt  = 0;
    repeat (30) begin
      @(negedge clk);
      if (rom_rd === 1'b1) rd_cnt++;
      if (out_valid === 1'b1) v_cnt++;
    end
    check("s4_idle_reads", rd_cnt, 0);
    check("s4_idle_valids", v_cnt, 0);
    q_big.push_back(model(52, HALF, OFF_B, OFF_C));
    en = 1'b1;
    wait_first_read("s4_reenable", 12);
    check_read_seq("s4", 52);

    // Scenario 5: reset during RD_C of the p=53 sample
    wait_read_start("s5");
    @(negedge clk);
    @(negedge clk);
    check("s5_in_rd_c", rom_rd, 1);
    #1 rst_n = 1'b0;
    #1;
    check("s5_async_out_a", out_a, 0);
    check("s5_async_out_b", out_b, 0);
    check("s5_async_out_c", out_c, 0);
    check("s5_async_rom_rd", rom_rd, 0);
    check("s5_async_busy", busy, 0);
    v_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid === 1'b1) v_cnt++;
    end
    check("s5_no_valid", v_cnt, 0);
    q_big.push_back(model(0, HALF, OFF_B, OFF_C));
    rst_n = 1'b1;
    wait_first_read("s5_restart", 12);
    check_read_seq("s5", 0);
    check("s5_out_b_const", out_b, 12'd523);
    check("s5_out_c_const", out_c, 12'hAFB);
    en = 1'b0;

    // Scenario 3: small table, p = 0..15 then wrap to 0, 1
    for (int k = 0; k < 18; k++) q_small.push_back(model(k % 16, S_HALF, S_OFFB, S_OFFC));
    rst_s = 1'b1;
    for (int k = 0; k < 18; k++) begin
      int p;
      p = k % 16;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (rom_rd_s !== 1'b1 && n < 20);
      check("s3_read_start", rom_rd_s, 1);
      if (k == 0) check("s3_tick_latency", n, 6);
      check("s3_addr_a", rom_addr_s, fold_addr(p, S_HALF));
      @(negedge clk);
      check("s3_addr_b", rom_addr_s, fold_addr(wrap_pos(p, S_OFFB, S_HALF), S_HALF));
      @(negedge clk);
      check("s3_addr_c", rom_addr_s, fold_addr(wrap_pos(p, S_OFFC, S_HALF), S_HALF));
      @(negedge clk);
      @(negedge clk);
      check("s3_valid", out_valid_s, 1);
    end
    en_s = 1'b0;

    repeat (10) @(negedge clk);
    check("big_queue_drained", q_big.size(), 0);
    check("small_queue_drained", q_small.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
